// File: rtl/rv_pkg.sv
// Shared RV32I decode types: opcode constants, operation classes, decoded-instruction
// record and the skid-buffer state encoding.
package rv_pkg;

  localparam logic [6:0] OPC_LUI      = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
  localparam logic [6:0] OPC_JAL      = 7'b1101111;
  localparam logic [6:0] OPC_JALR     = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
  localparam logic [6:0] OPC_LOAD     = 7'b0000011;
  localparam logic [6:0] OPC_STORE    = 7'b0100011;
  localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
  localparam logic [6:0] OPC_OP       = 7'b0110011;
  localparam logic [6:0] OPC_MISC_MEM = 7'b0001111;
  localparam logic [6:0] OPC_SYSTEM   = 7'b1110011;

  typedef enum logic [3:0] {
    CLS_ALU    = 4'd0,
    CLS_LUI    = 4'd1,
    CLS_AUIPC  = 4'd2,
    CLS_JAL    = 4'd3,
    CLS_JALR   = 4'd4,
    CLS_BRANCH = 4'd5,
    CLS_LOAD   = 4'd6,
    CLS_STORE  = 4'd7,
    CLS_NOP    = 4'd8,
    CLS_SYSTEM = 4'd9,
    CLS_MULDIV = 4'd10
  } op_class_e;

  typedef struct packed {
    logic [4:0]  rs1a;
    logic [4:0]  rs2a;
    logic [4:0]  rda;
    logic        w_en;
    logic        rs2val;
    logic [31:0] imm;
    op_class_e   op_class;
    logic [2:0]  funct3;
    logic        funct7b5;
    logic        illegal;
  } decoded_t;

  typedef enum logic [1:0] {
    BUF_EMPTY = 2'd0,
    BUF_BUSY  = 2'd1,
    BUF_FULL  = 2'd2
  } buf_state_e;

endpackage

// File: rtl/instr_decoder.sv
// Purely combinational RV32I instruction decoder. Optional M-extension encodings are
// accepted when DECODE_RV32M_EN is defined.
module instr_decoder
  import rv_pkg::*;
(
  input  logic [31:0] instr,
  output decoded_t    dec
);

  logic [6:0]  opcode;
  logic [6:0]  funct7;
  logic [2:0]  funct3;
  logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;
  logic        legal;
  logic        writes;
  logic        reads_rs2;
  op_class_e   cls;
  logic [31:0] imm_v;

  assign opcode = instr[6:0];
  assign funct7 = instr[31:25];
  assign funct3 = instr[14:12];

  assign imm_i = {{20{instr[31]}}, instr[31:20]};
  assign imm_s = {{20{instr[31]}}, instr[31:25], instr[11:7]};
  assign imm_b = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
  assign imm_u = {instr[31:12], 12'b0};
  assign imm_j = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};

  always_comb begin
    cls       = CLS_NOP;
    imm_v     = '0;
    writes    = 1'b0;
    reads_rs2 = 1'b0;
    legal     = 1'b1;
    case (opcode)
      OPC_LUI:      begin cls = CLS_LUI;    imm_v = imm_u; writes = 1'b1; end
      OPC_AUIPC:    begin cls = CLS_AUIPC;  imm_v = imm_u; writes = 1'b1; end
      OPC_JAL:      begin cls = CLS_JAL;    imm_v = imm_j; writes = 1'b1; end
      OPC_JALR:     begin cls = CLS_JALR;   imm_v = imm_i; writes = 1'b1; end
      OPC_BRANCH:   begin cls = CLS_BRANCH; imm_v = imm_b; reads_rs2 = 1'b1; end
      OPC_LOAD:     begin cls = CLS_LOAD;   imm_v = imm_i; writes = 1'b1; end
      OPC_STORE:    begin cls = CLS_STORE;  imm_v = imm_s; reads_rs2 = 1'b1; end
      OPC_OP_IMM: begin
        cls    = CLS_ALU;
        imm_v  = imm_i;
        writes = 1'b1;
        // Shift-immediates reuse the upper immediate bits as a funct7 selector.
        if (funct3 == 3'b001)      legal = (funct7 == 7'h00);
        else if (funct3 == 3'b101) legal = (funct7 == 7'h00) || (funct7 == 7'h20);
      end
      OPC_OP: begin
        cls       = CLS_ALU;
        writes    = 1'b1;
        reads_rs2 = 1'b1;
        if (funct7 == 7'h00)      legal = 1'b1;
        else if (funct7 == 7'h20) legal = (funct3 == 3'b000) || (funct3 == 3'b101);
`ifdef DECODE_RV32M_EN
        else if (funct7 == 7'h01) cls = CLS_MULDIV;
`endif
        else                      legal = 1'b0;
      end
      OPC_MISC_MEM: begin cls = CLS_NOP;    imm_v = imm_i; end
      OPC_SYSTEM:   begin cls = CLS_SYSTEM; imm_v = imm_i; end
      default:      legal = 1'b0;
    endcase
    if (instr[1:0] != 2'b11) legal = 1'b0;
  end

  // Illegal words still travel downstream, but never request a write or an rs2 read.
  always_comb begin
    dec          = '0;
    dec.rs1a     = instr[19:15];
    dec.rs2a     = instr[24:20];
    dec.rda      = instr[11:7];
    dec.w_en     = legal && writes && (instr[11:7] != 5'd0);
    dec.rs2val   = legal && reads_rs2;
    dec.imm      = imm_v;
    dec.op_class = legal ? cls : CLS_NOP;
    dec.funct3   = funct3;
    dec.funct7b5 = instr[30];
    dec.illegal  = !legal;
  end

endmodule

// File: rtl/decode_stage.sv
// RV32I decode stage: instr_decoder feeding a two-entry skid buffer (main M, skid S)
// with a registered in_ready. Optional M extension via DECODE_RV32M_EN.
// Handshake: a word moves on any rising edge where valid && ready; valid never depends
// on ready, and presented data holds while valid && !ready.
module decode_stage
  import rv_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_instr,
  input  logic [XLEN-1:0] in_pc,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [4:0]      rs1a,
  output logic [4:0]      rs2a,
  output logic [4:0]      rda,
  output logic            w_en,
  output logic            rs2val,
  output logic [31:0]     imm,
  output logic [XLEN-1:0] pc,
  output op_class_e       op_class,
  output logic [2:0]      funct3,
  output logic            funct7b5,
  output logic            illegal,
  output buf_state_e      dbg_state
);

  typedef struct packed {
    decoded_t        dec;
    logic [XLEN-1:0] pc;
  } entry_t;

  buf_state_e state_q, state_d;
  logic       in_ready_q;
  entry_t     m_q, s_q, in_entry;
  decoded_t   in_dec;
  logic       accept, drain;
  logic       load_m_in, load_m_skid, load_s;

  instr_decoder u_dec (
    .instr (in_instr),
    .dec   (in_dec)
  );

  assign in_entry = '{dec: in_dec, pc: in_pc};
  assign accept   = in_valid && in_ready_q;
  assign drain    = (state_q != BUF_EMPTY) && out_ready;

  always_comb begin
    state_d     = state_q;
    load_m_in   = 1'b0;
    load_m_skid = 1'b0;
    load_s      = 1'b0;
    if (flush) begin
      state_d = BUF_EMPTY;
    end else begin
      case (state_q)
        BUF_EMPTY: if (accept) begin
          state_d   = BUF_BUSY;
          load_m_in = 1'b1;
        end
        BUF_BUSY: begin
          if (accept && drain) begin
            load_m_in = 1'b1;
          end else if (accept) begin
            state_d = BUF_FULL;
            load_s  = 1'b1;
          end else if (drain) begin
            state_d = BUF_EMPTY;
          end
        end
        BUF_FULL: if (drain) begin
          state_d     = BUF_BUSY;
          load_m_skid = 1'b1;
        end
        default: state_d = BUF_EMPTY;
      endcase
    end
  end

  // in_ready is 0 throughout reset and rises on the first edge afterwards.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= BUF_EMPTY;
      in_ready_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      in_ready_q <= (state_d != BUF_FULL);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_q <= '0;
      s_q <= '0;
    end else begin
      if (load_m_in)        m_q <= in_entry;
      else if (load_m_skid) m_q <= s_q;
      if (load_s)           s_q <= in_entry;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = (state_q != BUF_EMPTY);
  assign rs1a      = m_q.dec.rs1a;
  assign rs2a      = m_q.dec.rs2a;
  assign rda       = m_q.dec.rda;
  assign w_en      = m_q.dec.w_en;
  assign rs2val    = m_q.dec.rs2val;
  assign imm       = m_q.dec.imm;
  assign pc        = m_q.pc;
  assign op_class  = m_q.dec.op_class;
  assign funct3    = m_q.dec.funct3;
  assign funct7b5  = m_q.dec.funct7b5;
  assign illegal   = m_q.dec.illegal;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_decode_stage.sv
// Directed self-checking bench for decode_stage; honours DECODE_RV32M_EN for MUL expectations.
module tb_decode_stage;
  import rv_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n, flush, in_valid, out_ready;
  logic [31:0] in_instr, in_pc;
  logic        in_ready, out_valid;
  logic [4:0]  rs1a, rs2a, rda;
  logic        w_en, rs2val, funct7b5, illegal;
  logic [31:0] imm, pc;
  logic [2:0]  funct3;
  op_class_e   op_class;
  buf_state_e  dbg_state;

  int checks   = 0;
  int failures = 0;

  logic [36:0] exp_q[$];

  typedef struct packed {
    logic [31:0] instr;
    logic [4:0]  rs1, rs2, rd;
    logic        w, r2;
    logic [31:0] imm;
    logic [3:0]  cls;
    logic        ill;
  } vec_t;

  localparam int NV = 17;
  vec_t vecs [NV];

  always #5 clk = ~clk;

  decode_stage #(.XLEN(32)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr), .in_pc(in_pc),
    .out_valid(out_valid), .out_ready(out_ready),
    .rs1a(rs1a), .rs2a(rs2a), .rda(rda), .w_en(w_en), .rs2val(rs2val),
    .imm(imm), .pc(pc), .op_class(op_class), .funct3(funct3), .funct7b5(funct7b5),
    .illegal(illegal), .dbg_state(dbg_state)
  );

  function automatic logic [31:0] addi_word(int k);
    return (32'(k + 10) << 20) | (32'(k + 1) << 7) | 32'h13;
  endfunction

  task automatic test_reset();
    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_instr = '0; in_pc = '0;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
    checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL reset_in_ready got=%b exp=0", in_ready); end
    checks++; if ({w_en, rs2val, illegal} !== 3'b000) begin failures++; $display("FAIL reset_flags got=%b exp=000", {w_en, rs2val, illegal}); end
    checks++; if ({rs1a, rs2a, rda, funct3, funct7b5} !== 19'd0) begin failures++; $display("FAIL reset_fields got=%h exp=0", {rs1a, rs2a, rda, funct3, funct7b5}); end
    checks++; if ({imm, pc} !== 64'd0 || op_class !== CLS_ALU) begin failures++; $display("FAIL reset_imm_pc_class got=%h/%h/%0d exp=0/0/0", imm, pc, op_class); end
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL reset_release_in_ready got=%b exp=1", in_ready); end
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_release_out_valid got=%b exp=0", out_valid); end
  endtask

  task automatic test_decode_table();
    vecs[0]  = '{32'h00500093, 5'd0, 5'd5,  5'd1,  1'b1, 1'b0, 32'd5,        CLS_ALU,    1'b0}; // addi x1,x0,5
    vecs[1]  = '{32'h002081B3, 5'd1, 5'd2,  5'd3,  1'b1, 1'b1, 32'd0,        CLS_ALU,    1'b0}; // add x3,x1,x2
    vecs[2]  = '{32'h0020A423, 5'd1, 5'd2,  5'd8,  1'b0, 1'b1, 32'd8,        CLS_STORE,  1'b0}; // sw x2,8(x1)
    vecs[3]  = '{32'h00000013, 5'd0, 5'd0,  5'd0,  1'b0, 1'b0, 32'd0,        CLS_ALU,    1'b0}; // nop: rd=x0
    vecs[4]  = '{32'h123452B7, 5'd8, 5'd3,  5'd5,  1'b1, 1'b0, 32'h12345000, CLS_LUI,    1'b0};
    vecs[5]  = '{32'hFE208EE3, 5'd1, 5'd2,  5'd29, 1'b0, 1'b1, 32'hFFFFFFFC, CLS_BRANCH, 1'b0}; // beq -4
    vecs[6]  = '{32'h008000EF, 5'd0, 5'd8,  5'd1,  1'b1, 1'b0, 32'd8,        CLS_JAL,    1'b0};
    vecs[7]  = '{32'h402081B3, 5'd1, 5'd2,  5'd3,  1'b1, 1'b1, 32'd0,        CLS_ALU,    1'b0}; // sub
    vecs[8]  = '{32'h402091B3, 5'd1, 5'd2,  5'd3,  1'b0, 1'b0, 32'd0,        CLS_NOP,    1'b1}; // sll with f7=0x20
    vecs[9]  = '{32'h4030D093, 5'd1, 5'd3,  5'd1,  1'b1, 1'b0, 32'h403,      CLS_ALU,    1'b0}; // srai
    vecs[10] = '{32'h40309093, 5'd1, 5'd3,  5'd1,  1'b0, 1'b0, 32'h403,      CLS_NOP,    1'b1}; // slli bad f7
    vecs[11] = '{32'h00000001, 5'd0, 5'd0,  5'd0,  1'b0, 1'b0, 32'd0,        CLS_NOP,    1'b1}; // low bits 01
    vecs[12] = '{32'h00000073, 5'd0, 5'd0,  5'd0,  1'b0, 1'b0, 32'd0,        CLS_SYSTEM, 1'b0}; // ecall
    vecs[13] = '{32'h0FF0000F, 5'd0, 5'd31, 5'd0,  1'b0, 1'b0, 32'hFF,       CLS_NOP,    1'b0}; // fence
    vecs[14] = '{32'hFFC12283, 5'd2, 5'd28, 5'd5,  1'b1, 1'b0, 32'hFFFFFFFC, CLS_LOAD,   1'b0}; // lw x5,-4(x2)
    vecs[15] = '{32'h00001017, 5'd0, 5'd0,  5'd0,  1'b0, 1'b0, 32'h1000,     CLS_AUIPC,  1'b0}; // auipc x0
    vecs[16] = '{32'h000280E7, 5'd5, 5'd0,  5'd1,  1'b1, 1'b0, 32'd0,        CLS_JALR,   1'b0};
    out_ready = 1'b1;
    for (int i = 0; i < NV; i++) begin
      @(negedge clk);
      in_valid = 1'b1; in_instr = vecs[i].instr; in_pc = 32'h1000 + 32'(4 * i);
      @(posedge clk); #1;
      checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL vec%0d out_valid got=%b exp=1", i, out_valid); end
      checks++; if ({rs1a, rs2a, rda} !== {vecs[i].rs1, vecs[i].rs2, vecs[i].rd}) begin failures++;
        $display("FAIL vec%0d regs got=%0d/%0d/%0d exp=%0d/%0d/%0d", i, rs1a, rs2a, rda, vecs[i].rs1, vecs[i].rs2, vecs[i].rd); end
      checks++; if ({w_en, rs2val, illegal} !== {vecs[i].w, vecs[i].r2, vecs[i].ill}) begin failures++;
        $display("FAIL vec%0d w_en/rs2val/illegal got=%b exp=%b", i, {w_en, rs2val, illegal}, {vecs[i].w, vecs[i].r2, vecs[i].ill}); end
      checks++; if (imm !== vecs[i].imm) begin failures++; $display("FAIL vec%0d imm got=%h exp=%h", i, imm, vecs[i].imm); end
      checks++; if (op_class !== vecs[i].cls) begin failures++; $display("FAIL vec%0d op_class got=%0d exp=%0d", i, op_class, vecs[i].cls); end
      checks++; if (pc !== 32'h1000 + 32'(4 * i)) begin failures++; $display("FAIL vec%0d pc got=%h exp=%h", i, pc, 32'h1000 + 32'(4 * i)); end
      if (i == 7) begin
        checks++; if ({funct3, funct7b5} !== 4'b0001) begin failures++; $display("FAIL sub_funct got=%b exp=0001", {funct3, funct7b5}); end
      end
      if (i == 14) begin
        checks++; if (funct3 !== 3'b010) begin failures++; $display("FAIL lw_funct3 got=%b exp=010", funct3); end
      end
    end
    @(negedge clk) in_valid = 1'b0;
    @(posedge clk); #1;
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL table_drain out_valid got=%b exp=0", out_valid); end
  endtask

  task automatic test_stall_stream();
    int sent = 0, got = 0, c = 0, first_drop = -1;
    logic acc, drn;
    logic [36:0] exp_v;
    while (got < 5 && c < 40) begin
      @(negedge clk);
      out_ready = (c >= 3);
      in_valid  = (sent < 5);
      in_instr  = addi_word(sent);
      in_pc     = 32'h2000 + 32'(4 * sent);
      #4;
      acc = in_valid && in_ready;
      drn = out_valid && out_ready;
      if (!in_ready && first_drop < 0) first_drop = sent;
      if (out_valid) begin
        if (exp_q.size() == 0) begin
          checks++; failures++; $display("FAIL stream_unexpected_output rda=%0d exp=none", rda);
        end else begin
          exp_v = exp_q[0];
          checks++; if ({rda, imm} !== exp_v) begin failures++;
            $display("FAIL stream_data got=%0d/%h exp=%0d/%h", rda, imm, exp_v[36:32], exp_v[31:0]); end
        end
      end
      if (drn) begin
        if (exp_q.size() > 0) void'(exp_q.pop_front());
        got++;
      end else if (got > 0) begin
        checks++; failures++; $display("FAIL stream_bubble cycle=%0d got=stall exp=drain", c);
      end
      if (acc) begin
        exp_q.push_back({5'(sent + 1), 32'(sent + 10)});
        sent++;
      end
      c++;
    end
    checks++; if (got != 5) begin failures++; $display("FAIL stream_timeout got=%0d exp=5", got); end
    checks++; if (first_drop != 2) begin failures++; $display("FAIL stream_in_ready_drop got=%0d exp=2", first_drop); end
    @(negedge clk) in_valid = 1'b0;
    @(posedge clk); #1;
    checks++; if (out_valid !== 1'b0 || exp_q.size() != 0) begin failures++;
      $display("FAIL stream_leftover got=%b/%0d exp=0/0", out_valid, exp_q.size()); end
  endtask

  task automatic test_flush();
    out_ready = 1'b0;
    @(negedge clk);
    in_valid = 1'b1; in_instr = 32'hFFFFFFFF; in_pc = 32'h200;
    @(posedge clk); #1;
    checks++; if ({out_valid, illegal, w_en, rs2val} !== 4'b1100) begin failures++;
      $display("FAIL flush_illegal got=%b exp=1100", {out_valid, illegal, w_en, rs2val}); end
    checks++; if (pc !== 32'h200) begin failures++; $display("FAIL flush_illegal_pc got=%h exp=200", pc); end
    @(negedge clk) in_instr = 32'h00500093;
    @(posedge clk); #1;
    checks++; if (in_ready !== 1'b0 || dbg_state !== BUF_FULL) begin failures++;
      $display("FAIL flush_full got=%b/%0d exp=0/2", in_ready, dbg_state); end
    checks++; if (illegal !== 1'b1 || pc !== 32'h200) begin failures++;
      $display("FAIL flush_hold got=%b/%h exp=1/200", illegal, pc); end
    @(negedge clk);
    flush = 1'b1; in_instr = 32'h002081B3;
    @(posedge clk); #1;
    checks++; if ({out_valid, in_ready} !== 2'b01) begin failures++;
      $display("FAIL flush_full_clear got=%b exp=01", {out_valid, in_ready}); end
    @(negedge clk);
    in_valid = 1'b1;
    @(posedge clk); #1;
    checks++; if (out_valid !== 1'b0 || dbg_state !== BUF_EMPTY) begin failures++;
      $display("FAIL flush_discard got=%b/%0d exp=0/0", out_valid, dbg_state); end
    @(negedge clk);
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    @(posedge clk); #1;
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL flush_after got=%b exp=0", out_valid); end
  endtask

  task automatic test_muldiv();
    out_ready = 1'b1;
    @(negedge clk);
    in_valid = 1'b1; in_instr = 32'h027302B3; in_pc = 32'h300;
    @(posedge clk); #1;
    checks++; if ({out_valid, rs1a, rs2a, rda} !== {1'b1, 5'd6, 5'd7, 5'd5}) begin failures++;
      $display("FAIL mul_regs got=%b/%0d/%0d/%0d exp=1/6/7/5", out_valid, rs1a, rs2a, rda); end
`ifdef DECODE_RV32M_EN
    checks++; if ({w_en, rs2val, illegal} !== 3'b110 || op_class !== CLS_MULDIV) begin failures++;
      $display("FAIL mul_decode got=%b/%0d exp=110/10", {w_en, rs2val, illegal}, op_class); end
`else
    checks++; if ({w_en, rs2val, illegal} !== 3'b001) begin failures++;
      $display("FAIL mul_decode got=%b exp=001", {w_en, rs2val, illegal}); end
`endif
    @(negedge clk) in_valid = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_mid_reset();
    out_ready = 1'b0;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      in_valid = 1'b1; in_instr = addi_word(k); in_pc = 32'h400;
    end
    @(posedge clk); #1;
    checks++; if (dbg_state !== BUF_FULL) begin failures++; $display("FAIL midreset_fill got=%0d exp=2", dbg_state); end
    @(negedge clk);
    in_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    checks++; if ({out_valid, in_ready, w_en} !== 3'b000 || dbg_state !== BUF_EMPTY) begin failures++;
      $display("FAIL midreset_clear got=%b/%0d exp=000/0", {out_valid, in_ready, w_en}, dbg_state); end
    checks++; if ({rda, imm, pc} !== 69'd0) begin failures++;
      $display("FAIL midreset_data got=%0d/%h/%h exp=0/0/0", rda, imm, pc); end
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    checks++; if ({in_ready, out_valid} !== 2'b10) begin failures++;
      $display("FAIL midreset_release got=%b exp=10", {in_ready, out_valid}); end
  endtask

  initial begin
    test_reset();
    test_decode_table();
    test_stall_stream();
    test_flush();
    test_muldiv();
    test_mid_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
